// File: rtl/memory_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage and data memory.
// Latency: none (wires only); the master holds a request until mem_ack.
// Backpressure: the memory stretches an access by withholding mem_ack.
interface memory_stage_if #(
  parameter int DATA_W = 19,
  parameter int ADDR_W = 16
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_byte;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_byte,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_byte,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/memory_stage.sv
// Pipeline MEM stage: load/store over a req/ack bus, produces the MEM/WB register.
// Latency: 1 cycle M->W, plus the cycles spent waiting for mem_ack on a memory op.
// Backpressure: stall_m freezes upstream while an access is outstanding; optional MEM_TIMEOUT_EN faults stuck accesses.
module memory_stage #(
  parameter int DATA_W         = 19,
  parameter int ADDR_W         = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWriteM,
  input  logic              MemWriteM,
  input  logic              ResultSrcM,
  input  logic [4:0]        RDM,
  input  logic [DATA_W-1:0] WriteDataM,
  input  logic [DATA_W-1:0] ALUResultM,
  input  logic              Cant_ByteM,
  memory_stage_if.master    dmem,
  output logic              stall_m,
  output logic              RegWriteW,
  output logic              ResultSrcW,
  output logic [4:0]        RDW,
  output logic [DATA_W-1:0] ALUResultW,
  output logic [DATA_W-1:0] ReadDataW,
  output logic              mem_fault
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FAULT} state_t;

  state_t state_q, state_d;
  logic   mem_op;
  logic   mem_req;
  logic   load_done;
  logic   bubble;

  logic              reg_write_q, reg_write_d;
  logic              result_src_q, result_src_d;
  logic [4:0]        rd_q, rd_d;
  logic [DATA_W-1:0] alu_result_q, alu_result_d;
  logic [DATA_W-1:0] read_data_q, read_data_d;
  logic [DATA_W-1:0] load_data;

  // A store wins over a load when both flags are set.
  assign mem_op = MemWriteM | ResultSrcM;

  // Address/data come straight from the M inputs; upstream is frozen while we wait.
  assign dmem.mem_we    = MemWriteM;
  assign dmem.mem_addr  = ALUResultM[ADDR_W-1:0];
  assign dmem.mem_byte  = Cant_ByteM;
  assign dmem.mem_wdata = Cant_ByteM ? {{(DATA_W-8){1'b0}}, WriteDataM[7:0]} : WriteDataM;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             mem_fault_q, mem_fault_d;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: enter WAIT when the first request cycle is not acknowledged.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (mem_op && !dmem.mem_ack) state_d = S_WAIT;
      S_WAIT: begin
        if (dmem.mem_ack) state_d = S_IDLE;
`ifdef MEM_TIMEOUT_EN
        else if (wait_cnt_q == CNT_LAST) state_d = S_FAULT;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: request is combinational so a zero-wait memory never stalls.
  always_comb begin
    mem_req = ((state_q == S_IDLE) && mem_op) || (state_q == S_WAIT);
    stall_m = mem_req && !dmem.mem_ack;
  end

  assign dmem.mem_req = mem_req;

`ifdef MEM_TIMEOUT_EN
  // Wait counter and sticky fault flag.
  always_comb begin
    wait_cnt_d  = wait_cnt_q;
    mem_fault_d = mem_fault_q || (state_d == S_FAULT);
    if (state_q != S_WAIT && state_d == S_WAIT) wait_cnt_d = '0;
    else if (state_q == S_WAIT && wait_cnt_q != CNT_MAX) wait_cnt_d = wait_cnt_q + CNT_W'(1);
  end

  // Timeout bookkeeping registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt_q  <= '0;
      mem_fault_q <= 1'b0;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      mem_fault_q <= mem_fault_d;
    end
  end

  assign mem_fault = mem_fault_q;
  // The faulting op retires as a bubble during the FAULT cycle.
  assign bubble    = stall_m || (state_q == S_FAULT);
`else
  assign mem_fault = 1'b0;
  assign bubble    = stall_m;
`endif

  // Load data only counts when a pure load is acknowledged this cycle.
  assign load_done = mem_req && dmem.mem_ack && ResultSrcM && !MemWriteM;
  assign load_data = Cant_ByteM ? {{(DATA_W-8){1'b0}}, dmem.mem_rdata[7:0]} : dmem.mem_rdata;

  // MEM/WB next value: bubble while stalled, otherwise pass the M fields.
  always_comb begin
    reg_write_d  = 1'b0;
    result_src_d = 1'b0;
    rd_d         = '0;
    alu_result_d = '0;
    read_data_d  = '0;
    if (!bubble) begin
      reg_write_d  = RegWriteM;
      result_src_d = ResultSrcM;
      rd_d         = RDM;
      alu_result_d = ALUResultM;
      read_data_d  = load_done ? load_data : '0;
    end
  end

  // MEM/WB pipeline register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reg_write_q  <= 1'b0;
      result_src_q <= 1'b0;
      rd_q         <= '0;
      alu_result_q <= '0;
      read_data_q  <= '0;
    end else begin
      reg_write_q  <= reg_write_d;
      result_src_q <= result_src_d;
      rd_q         <= rd_d;
      alu_result_q <= alu_result_d;
      read_data_q  <= read_data_d;
    end
  end

  assign RegWriteW  = reg_write_q;
  assign ResultSrcW = result_src_q;
  assign RDW        = rd_q;
  assign ALUResultW = alu_result_q;
  assign ReadDataW  = read_data_q;

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: vector table plus multi-cycle sequences.
// Expected MEM/WB values are queued when a cycle is driven and compared after the edge.
// Timeout sequence is exercised only when MEM_TIMEOUT_EN is defined.
module tb_memory_stage;
  localparam int DW = 19;
  localparam int AW = 16;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          RegWriteM, MemWriteM, ResultSrcM, Cant_ByteM;
  logic [4:0]    RDM;
  logic [DW-1:0] WriteDataM, ALUResultM;
  logic          stall_m, RegWriteW, ResultSrcW, mem_fault;
  logic [4:0]    RDW;
  logic [DW-1:0] ALUResultW, ReadDataW;

  memory_stage_if #(.DATA_W(DW), .ADDR_W(AW)) dmem ();

  memory_stage #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .RDM(RDM), .WriteDataM(WriteDataM), .ALUResultM(ALUResultM), .Cant_ByteM(Cant_ByteM),
    .dmem(dmem.master), .stall_m(stall_m),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RDW(RDW),
    .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .mem_fault(mem_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rw, rs;
    logic [4:0]    rd;
    logic [DW-1:0] alu, rdat;
  } w_t;

  typedef struct {
    logic          rw, mw, rs;
    logic [4:0]    rd;
    logic [DW-1:0] wd, alu;
    logic          byt, ack;
    logic [DW-1:0] rdata;
    logic          e_req, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic          e_byte, e_stall;
    w_t            w;
  } vec_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic exp_fault = 1'b0;
  w_t   sb_q[$];

  function automatic vec_t mk(
    logic rw, logic mw, logic rs, logic [4:0] rd, logic [DW-1:0] wd, logic [DW-1:0] alu,
    logic byt, logic ack, logic [DW-1:0] rdata,
    logic e_req, logic e_we, logic [AW-1:0] e_addr, logic [DW-1:0] e_wdata, logic e_byte, logic e_stall,
    logic w_rw, logic w_rs, logic [4:0] w_rd, logic [DW-1:0] w_alu, logic [DW-1:0] w_rdat);
    vec_t v;
    v.rw = rw; v.mw = mw; v.rs = rs; v.rd = rd; v.wd = wd; v.alu = alu;
    v.byt = byt; v.ack = ack; v.rdata = rdata;
    v.e_req = e_req; v.e_we = e_we; v.e_addr = e_addr; v.e_wdata = e_wdata;
    v.e_byte = e_byte; v.e_stall = e_stall;
    v.w.rw = w_rw; v.w.rs = w_rs; v.w.rd = w_rd; v.w.alu = w_alu; v.w.rdat = w_rdat;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_w(input string tag, input w_t e);
    chk({tag, ".RegWriteW"},  32'(RegWriteW),  32'(e.rw));
    chk({tag, ".ResultSrcW"}, 32'(ResultSrcW), 32'(e.rs));
    chk({tag, ".RDW"},        32'(RDW),        32'(e.rd));
    chk({tag, ".ALUResultW"}, 32'(ALUResultW), 32'(e.alu));
    chk({tag, ".ReadDataW"},  32'(ReadDataW),  32'(e.rdat));
  endtask

  // One pipeline cycle: drive at posedge+1, check comb outputs, check W after the edge.
  task automatic step(input vec_t v, input string tag);
    w_t e;
    RegWriteM = v.rw; MemWriteM = v.mw; ResultSrcM = v.rs; RDM = v.rd;
    WriteDataM = v.wd; ALUResultM = v.alu; Cant_ByteM = v.byt;
    dmem.mem_ack = v.ack; dmem.mem_rdata = v.rdata;
    #1;
    chk({tag, ".mem_req"},   32'(dmem.mem_req),   32'(v.e_req));
    chk({tag, ".mem_we"},    32'(dmem.mem_we),    32'(v.e_we));
    chk({tag, ".mem_addr"},  32'(dmem.mem_addr),  32'(v.e_addr));
    chk({tag, ".mem_wdata"}, 32'(dmem.mem_wdata), 32'(v.e_wdata));
    chk({tag, ".mem_byte"},  32'(dmem.mem_byte),  32'(v.e_byte));
    chk({tag, ".stall_m"},   32'(stall_m),        32'(v.e_stall));
    chk({tag, ".mem_fault"}, 32'(mem_fault),      32'(exp_fault));
    sb_q.push_back(v.w);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk_w(tag, e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[8];
    vec_t nop, ld, st;
    w_t   zero_w;

    zero_w = '{rw: 1'b0, rs: 1'b0, rd: 5'd0, alu: '0, rdat: '0};
    //          rw mw rs rd  wd        alu       by ack rdata      req we addr      wdata     by st  Wrw Wrs Wrd alu       rdat
    tbl[0] = mk(1, 0, 0, 5,  19'h0,     19'h01234, 0, 0, 19'h0,     0, 0, 16'h1234, 19'h0,     0, 0, 1, 0, 5,  19'h01234, 19'h0);
    tbl[1] = mk(0, 1, 0, 0,  19'h5A3C7, 19'h00100, 1, 1, 19'h0,     1, 1, 16'h0100, 19'h000C7, 1, 0, 0, 0, 0,  19'h00100, 19'h0);
    tbl[2] = mk(1, 0, 1, 7,  19'h0,     19'h00200, 1, 1, 19'h7FFFF, 1, 0, 16'h0200, 19'h0,     1, 0, 1, 1, 7,  19'h00200, 19'h000FF);
    tbl[3] = mk(1, 1, 0, 3,  19'h4ABCD, 19'h7FFF0, 0, 1, 19'h0,     1, 1, 16'hFFF0, 19'h4ABCD, 0, 0, 1, 0, 3,  19'h7FFF0, 19'h0);
    tbl[4] = mk(1, 0, 0, 9,  19'h0,     19'h00055, 0, 1, 19'h12345, 0, 0, 16'h0055, 19'h0,     0, 0, 1, 0, 9,  19'h00055, 19'h0);
    tbl[5] = mk(1, 0, 1, 31, 19'h0,     19'h00044, 0, 1, 19'h6DEAD, 1, 0, 16'h0044, 19'h0,     0, 0, 1, 1, 31, 19'h00044, 19'h6DEAD);
    tbl[6] = mk(0, 1, 1, 2,  19'h11111, 19'h00300, 0, 1, 19'h22222, 1, 1, 16'h0300, 19'h11111, 0, 0, 0, 1, 2,  19'h00300, 19'h0);
    tbl[7] = mk(1, 0, 1, 12, 19'h7FFFF, 19'h00301, 1, 1, 19'h54321, 1, 0, 16'h0301, 19'h000FF, 1, 0, 1, 1, 12, 19'h00301, 19'h00021);
    nop    = mk(0, 0, 0, 0,  19'h0,     19'h0,     0, 0, 19'h0,     0, 0, 16'h0,    19'h0,     0, 0, 0, 0, 0,  19'h0,     19'h0);

    // Reset state.
    reset = 1'b0;
    RegWriteM = 0; MemWriteM = 0; ResultSrcM = 0; RDM = '0;
    WriteDataM = '0; ALUResultM = '0; Cant_ByteM = 0;
    dmem.mem_ack = 0; dmem.mem_rdata = '0;
    #12;
    chk("rst.mem_req", 32'(dmem.mem_req), 32'd0);
    chk("rst.stall_m", 32'(stall_m), 32'd0);
    chk("rst.mem_fault", 32'(mem_fault), 32'd0);
    chk_w("rst", zero_w);
    reset = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) step(tbl[i], $sformatf("vec%0d", i));

    // Word load, ack in the third request cycle.
    ld = mk(1, 0, 1, 4, 19'h0, 19'h00040, 0, 0, 19'h0, 1, 0, 16'h0040, 19'h0, 0, 1, 0, 0, 0, 19'h0, 19'h0);
    step(ld, "wl.c1");
    step(ld, "wl.c2");
    step(mk(1, 0, 1, 4, 19'h0, 19'h00040, 0, 1, 19'h7ABCD, 1, 0, 16'h0040, 19'h0, 0, 0, 1, 1, 4, 19'h00040, 19'h7ABCD), "wl.c3");
    step(tbl[0], "wl.after");

    // Byte store, ack one cycle late.
    st = mk(0, 1, 0, 8, 19'h12345, 19'h00500, 1, 0, 19'h0, 1, 1, 16'h0500, 19'h00045, 1, 1, 0, 0, 0, 19'h0, 19'h0);
    step(st, "bs.c1");
    st.ack = 1'b1; st.e_stall = 1'b0;
    st.w = '{rw: 1'b0, rs: 1'b0, rd: 5'd8, alu: 19'h00500, rdat: 19'h0};
    step(st, "bs.c2");

`ifdef MEM_TIMEOUT_EN
    // Load that never completes: four WAIT cycles, then FAULT, then normal operation.
    ld = mk(1, 0, 1, 6, 19'h0, 19'h00080, 0, 0, 19'h0, 1, 0, 16'h0080, 19'h0, 0, 1, 0, 0, 0, 19'h0, 19'h0);
    step(ld, "to.idle");
    for (int i = 0; i < TO; i++) step(ld, $sformatf("to.wait%0d", i));
    exp_fault = 1'b1;
    step(mk(1, 0, 1, 6, 19'h0, 19'h00080, 0, 0, 19'h0, 0, 0, 16'h0080, 19'h0, 0, 0, 0, 0, 0, 19'h0, 19'h0), "to.fault");
    step(tbl[0], "to.after");
    step(tbl[5], "to.after_ld");
`endif

    // Reset asserted while a load sits in WAIT.
    ld = mk(1, 0, 1, 10, 19'h0, 19'h00600, 0, 0, 19'h0, 1, 0, 16'h0600, 19'h0, 0, 1, 0, 0, 0, 19'h0, 19'h0);
    step(ld, "rw.c1");
    RegWriteM = 0; MemWriteM = 0; ResultSrcM = 0; RDM = '0;
    ALUResultM = '0; Cant_ByteM = 0; dmem.mem_ack = 0;
    reset = 1'b0;
    exp_fault = 1'b0;
    #1;
    chk("rw.mem_req", 32'(dmem.mem_req), 32'd0);
    chk("rw.stall_m", 32'(stall_m), 32'd0);
    chk("rw.mem_fault", 32'(mem_fault), 32'd0);
    chk_w("rw.inrst", zero_w);
    @(posedge clk);
    #1;
    chk_w("rw.held", zero_w);
    reset = 1'b1;
    step(nop, "rw.idle");
    step(ld, "rw.ld1");
    step(mk(1, 0, 1, 10, 19'h0, 19'h00600, 0, 1, 19'h13579, 1, 0, 16'h0600, 19'h0, 0, 0, 1, 1, 10, 19'h00600, 19'h13579), "rw.ld2");
    step(nop, "rw.tail");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
